conway_engine: RTL and testbench

Parametrised Game-of-Life state engine, the next-generation replacement for the fixed 64×48 game-state block. Holds a WIDTH×HEIGHT cell grid, advances it one generation per accepted tick using a row-serial update (one row per cycle), supports toroidal or dead-border edges, and stamps PAT×PAT patterns at a cursor. It sits between the game-rate clock divider, cursor/pattern inputs and the VGA display, which reads `state` directly.

---
 rtl/conway_pkg.sv | 35 +++
 rtl/conway_row_calc.sv | 38 +++
 rtl/conway_engine.sv | 172 +++++++++++++++++
 tb/tb_conway_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Game-of-Life engine: FSM encoding,
// cell addressing, edge handling and the B3/S23 rule.
package conway_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } fsm_t;

  // Flat bit position of cell (x,y) in a row-major grid
  function automatic int cell_index(input int x, input int y, input int width);
    return y * width + x;
  endfunction

  // Map a coordinate onto the grid: modulo size when wrapping, -1 when it
  // falls outside a dead-bordered grid
  function automatic int wrap_coord(input int c, input int size, input logic wrap);
    int r;
    if (c >= 0 && c < size) begin
      r = c;
    end else if (wrap) begin
      r = ((c % size) + size) % size;
    end else begin
      r = -1;
    end
    return r;
  endfunction

  // B3/S23: birth on exactly three neighbours, survival on two or three
  function automatic logic life_rule(input logic alive, input logic [3:0] count);
    return (count == 4'd3) || (alive && (count == 4'd2));
  endfunction

endpackage

// File: rtl/conway_row_calc.sv
// Combinational next-generation calculation for one grid row, given the
// row above, the row itself and the row below (already edge-resolved).
module conway_row_calc
  import conway_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int WRAP  = 1
) (
  input  logic [WIDTH-1:0] row_up,
  input  logic [WIDTH-1:0] row_mid,
  input  logic [WIDTH-1:0] row_dn,
  output logic [WIDTH-1:0] row_next
);

  logic [3:0] count;
  int         xi;

  // Count the eight neighbours of every column and apply the life rule
  always_comb begin
    row_next = '0;
    count    = 4'd0;
    xi       = 0;
    for (int x = 0; x < WIDTH; x++) begin
      count = 4'd0;
      for (int dx = -1; dx <= 1; dx++) begin
        xi = wrap_coord(x + dx, WIDTH, WRAP != 0);
        if (xi >= 0) begin
          count = count + {3'd0, row_up[xi]} + {3'd0, row_dn[xi]}
                + ((dx != 0) ? {3'd0, row_mid[xi]} : 4'd0);
        end else begin
          count = count;
        end
      end
      row_next[x] = life_rule(row_mid[x], count);
    end
  end

endmodule

// File: rtl/conway_engine.sv
// Game-of-Life state engine: holds the grid, advances it one generation per
// accepted tick by computing one row per cycle into a shadow buffer, then
// commits the whole buffer at once. Also stamps patterns at a cursor.
module conway_engine
  import conway_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 48,
  parameter int WRAP   = 1,
  parameter int PAT    = 8,
  parameter int GEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      freeze,
  input  logic                      load,
  input  logic                      clear,
  input  logic [PAT*PAT-1:0]        pattern,
  input  logic [7:0]                cursor_x,
  input  logic [7:0]                cursor_y,
  output logic [WIDTH*HEIGHT-1:0]   state,
  output logic                      busy,
  output logic                      done,
  output logic [GEN_W-1:0]          gen_count
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  fsm_t             fsm, fsm_next;
  logic [ROW_W-1:0] row;
  logic [CELLS-1:0] grid, next_buf, stamp_grid;
  logic [WIDTH-1:0] row_up, row_mid, row_dn, row_new;
  logic             busy_r, done_r;
  logic [GEN_W-1:0] gen_r;
  int               up_idx, dn_idx, sx, sy;

  // Fetch the current row and its vertical neighbours, dead rows off-grid
  always_comb begin
    up_idx  = wrap_coord(int'(row) - 1, HEIGHT, WRAP != 0);
    dn_idx  = wrap_coord(int'(row) + 1, HEIGHT, WRAP != 0);
    row_mid = grid[int'(row) * WIDTH +: WIDTH];
    if (up_idx >= 0) begin
      row_up = grid[up_idx * WIDTH +: WIDTH];
    end else begin
      row_up = '0;
    end
    if (dn_idx >= 0) begin
      row_dn = grid[dn_idx * WIDTH +: WIDTH];
    end else begin
      row_dn = '0;
    end
  end

  conway_row_calc #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_row_calc (
    .row_up   (row_up),
    .row_mid  (row_mid),
    .row_dn   (row_dn),
    .row_next (row_new)
  );

  // Build the grid as it would look after overwriting the pattern window
  always_comb begin
    stamp_grid = grid;
    sx         = 0;
    sy         = 0;
    for (int py = 0; py < PAT; py++) begin
      for (int px = 0; px < PAT; px++) begin
        sx = wrap_coord(int'(cursor_x) + px, WIDTH, WRAP != 0);
        sy = wrap_coord(int'(cursor_y) + py, HEIGHT, WRAP != 0);
        if (sx >= 0 && sy >= 0) begin
          stamp_grid[cell_index(sx, sy, WIDTH)] = pattern[py * PAT + px];
        end else begin
          stamp_grid = stamp_grid;
        end
      end
    end
  end

  // Next-state logic; clear aborts any generation in progress
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      S_IDLE: begin
        if (clear || load) begin
          fsm_next = S_IDLE;
        end else if (tick && !freeze) begin
          fsm_next = S_CALC;
        end else begin
          fsm_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (clear) begin
          fsm_next = S_IDLE;
        end else if (row == LAST_ROW) begin
          fsm_next = S_COMMIT;
        end else begin
          fsm_next = S_CALC;
        end
      end
      S_COMMIT: fsm_next = S_IDLE;
      default:  fsm_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= S_IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Grid, shadow buffer, row counter, generation counter and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid     <= '0;
      next_buf <= '0;
      row      <= '0;
      gen_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (clear) begin
      grid     <= '0;
      next_buf <= '0;
      row      <= '0;
      gen_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (fsm_next != S_IDLE);
      done_r <= (fsm == S_COMMIT);
      case (fsm)
        S_IDLE: begin
          if (load) begin
            grid <= stamp_grid;
          end else if (tick && !freeze) begin
            row <= '0;
          end else begin
            row <= row;
          end
        end
        S_CALC: begin
          next_buf[int'(row) * WIDTH +: WIDTH] <= row_new;
          if (row != LAST_ROW) begin
            row <= row + 1'b1;
          end else begin
            row <= row;
          end
        end
        S_COMMIT: begin
          grid  <= next_buf;
          gen_r <= gen_r + 1'b1;
        end
        default: grid <= grid;
      endcase
    end
  end

  assign state     = grid;
  assign busy      = busy_r;
  assign done      = done_r;
  assign gen_count = gen_r;

endmodule

// File: tb/tb_conway_engine.sv
// Self-checking bench: three 8x8 engines (torus, dead border, 2-bit counter)
// driven in lockstep and compared against a behavioural life model.
module tb_conway_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0, freeze = 1'b0, load = 1'b0, clear = 1'b0;
  logic [63:0] pattern = 64'd0;
  logic [7:0]  cursor_x = 8'd0, cursor_y = 8'd0;
  logic [63:0] state_a, state_b, state_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] gen_a, gen_b;
  logic [1:0]  gen_c;

  always #5 clk = ~clk;

  conway_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .PAT(8), .GEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze), .load(load), .clear(clear),
    .pattern(pattern), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .state(state_a), .busy(busy_a), .done(done_a), .gen_count(gen_a));
  conway_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .PAT(8), .GEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze), .load(load), .clear(clear),
    .pattern(pattern), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .state(state_b), .busy(busy_b), .done(done_b), .gen_count(gen_b));
  conway_engine #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .PAT(8), .GEN_W(2)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze), .load(load), .clear(clear),
    .pattern(pattern), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .state(state_c), .busy(busy_c), .done(done_c), .gen_count(gen_c));

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_a, m_b, m_c;
  logic [15:0] mg_a, mg_b;
  logic [1:0]  mg_c;

  typedef struct {
    logic [63:0] sa, sb, sc;
    logic [15:0] ga, gb;
    logic [1:0]  gc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [63:0] start;
    int          ticks;
    logic [63:0] fin_a;
    logic [63:0] fin_b;
  } vec_t;
  vec_t vecs[6];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference generation step on an 8x8 grid
  function automatic logic [63:0] life_step(input logic [63:0] g, input bit wrap);
    logic [63:0] r;
    int n, xx, yy;
    r = 64'd0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
              xx = x + dx;
              yy = y + dy;
              if (wrap) begin
                xx = (xx + 8) % 8;
                yy = (yy + 8) % 8;
                n += int'(g[yy*8+xx]);
              end else if (xx >= 0 && xx < 8 && yy >= 0 && yy < 8) begin
                n += int'(g[yy*8+xx]);
              end
            end
          end
        end
        r[y*8+x] = (n == 3) || (g[y*8+x] && n == 2);
      end
    end
    return r;
  endfunction

  // Reference pattern stamp (overwrite) on an 8x8 grid with an 8x8 pattern
  function automatic logic [63:0] stamp(input logic [63:0] g, input logic [63:0] pat,
                                        input int cx, input int cy, input bit wrap);
    int x, y;
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        x = cx + px;
        y = cy + py;
        if (wrap) begin
          g[(y % 8)*8 + (x % 8)] = pat[py*8+px];
        end else if (x < 8 && y < 8) begin
          g[y*8+x] = pat[py*8+px];
        end
      end
    end
    return g;
  endfunction

  task automatic model_clear();
    m_a = 64'd0; m_b = 64'd0; m_c = 64'd0;
    mg_a = 16'd0; mg_b = 16'd0; mg_c = 2'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_clear();
  endtask

  task automatic do_load(input logic [63:0] pat, input int cx, input int cy);
    pattern = pat; cursor_x = 8'(cx); cursor_y = 8'(cy); load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    m_a = stamp(m_a, pat, cx, cy, 1'b1);
    m_b = stamp(m_b, pat, cx, cy, 1'b0);
    m_c = stamp(m_c, pat, cx, cy, 1'b1);
  endtask

  task automatic push_step();
    m_a = life_step(m_a, 1'b1);
    m_b = life_step(m_b, 1'b0);
    m_c = life_step(m_c, 1'b1);
    mg_a++; mg_b++; mg_c++;
    sb_q.push_back('{m_a, m_b, m_c, mg_a, mg_b, mg_c});
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done_a) break;
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty at done", tag);
    end else begin
      e = sb_q.pop_front();
      check64({tag, " state_a"}, state_a, e.sa);
      check64({tag, " state_b"}, state_b, e.sb);
      check64({tag, " state_c"}, state_c, e.sc);
      check64({tag, " gen_a"}, 64'(gen_a), 64'(e.ga));
      check64({tag, " gen_b"}, 64'(gen_b), 64'(e.gb));
      check64({tag, " gen_c"}, 64'(gen_c), 64'(e.gc));
      check64({tag, " done_bc"}, {62'd0, done_b, done_c}, 64'd3);
    end
  endtask

  task automatic run_tick(input string tag);
    int lat;
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    push_step();
    wait_done(lat);
    check64({tag, " latency"}, 64'(lat), 64'd10);
    pop_compare(tag);
    @(negedge clk);
    check64({tag, " done_one_cycle"}, {63'd0, done_a}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hits;
    vecs[0] = '{"blinker1", 64'h0000_0038_0000_0000, 1, 64'h0000_1010_1000_0000, 64'h0000_1010_1000_0000};
    vecs[1] = '{"blinker2", 64'h0000_0038_0000_0000, 2, 64'h0000_0038_0000_0000, 64'h0000_0038_0000_0000};
    vecs[2] = '{"glider32", 64'h0000_0000_0007_0402, 32, 64'h0000_0000_0007_0402, 64'hC0C0_0000_0000_0000};
    vecs[3] = '{"block", 64'h0000_0000_0C0C_0000, 3, 64'h0000_0000_0C0C_0000, 64'h0000_0000_0C0C_0000};
    vecs[4] = '{"edge_blinker", 64'h0000_0000_0000_0083, 1, 64'h0100_0000_0000_0101, 64'h0};
    vecs[5] = '{"empty", 64'h0, 4, 64'h0, 64'h0};

    // Reset state
    model_clear();
    repeat (2) @(negedge clk);
    check64("reset state", state_a | state_b | state_c, 64'd0);
    check64("reset gen", 64'(gen_a) | 64'(gen_b) | 64'(gen_c), 64'd0);
    check64("reset busy_done", {60'd0, busy_a, busy_b, done_a, done_b}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven generations
    for (int v = 0; v < 6; v++) begin
      do_clear();
      do_load(vecs[v].start, 0, 0);
      @(negedge clk);
      check64({vecs[v].name, " loaded"}, state_a, vecs[v].start);
      for (int t = 0; t < vecs[v].ticks; t++) run_tick(vecs[v].name);
      check64({vecs[v].name, " final_a"}, state_a, vecs[v].fin_a);
      check64({vecs[v].name, " final_b"}, state_b, vecs[v].fin_b);
      check64({vecs[v].name, " final_gen"}, 64'(gen_a), 64'(vecs[v].ticks));
      check64({vecs[v].name, " final_gen_c"}, 64'(gen_c), 64'(vecs[v].ticks % 4));
    end

    // Stamp at (6,6): wraps on the torus, clipped on the dead-border grid
    do_clear();
    do_load(64'h0000_0000_0F0F_0F0F, 6, 6);
    @(negedge clk);
    check64("load wrap", state_a, 64'hC3C3_0000_0000_C3C3);
    check64("load clip", state_b, 64'hC0C0_0000_0000_0000);
    check64("load model_b", state_b, m_b);
    do_load(64'h1, 0, 0);
    @(negedge clk);
    check64("load overwrite", state_a, 64'h1);

    // Clear at row 3 of CALC aborts without done
    do_clear();
    do_load(64'h0000_0038_0000_0000, 0, 0);
    run_tick("pre_clear");
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_clear();
    @(negedge clk);
    check64("abort state", state_a, 64'd0);
    check64("abort gen", 64'(gen_a), 64'd0);
    check64("abort busy", {63'd0, busy_a}, 64'd0);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a || busy_a) hits++;
    end
    check64("abort no_done", 64'(hits), 64'd0);

    // Tick and load during busy are ignored; freeze rising mid-CALC does not abort
    do_load(64'h0000_0038_0000_0000, 0, 0);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    push_step();
    repeat (2) @(posedge clk);
    #1 tick = 1'b1; load = 1'b1; pattern = {64{1'b1}};
    @(posedge clk); #1 tick = 1'b0; load = 1'b0; freeze = 1'b1;
    wait_done(lat);
    pop_compare("busy_ignore");
    freeze = 1'b0;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy_a) hits++;
    end
    check64("busy no_queue", 64'(hits), 64'd0);
    check64("busy state", state_a, m_a);

    // Tick with freeze in IDLE is ignored
    freeze = 1'b1; tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick = 1'b0; freeze = 1'b0;
    @(negedge clk);
    check64("freeze busy", {63'd0, busy_a}, 64'd0);
    check64("freeze gen", 64'(gen_a), 64'(mg_a));
    check64("freeze state", state_a, m_a);

    // Tick held: next generation starts in the done cycle
    tick = 1'b1;
    @(posedge clk); #1;
    push_step();
    push_step();
    wait_done(lat);
    check64("held latency1", 64'(lat), 64'd10);
    pop_compare("held1");
    check64("held busy_at_done", {63'd0, busy_a}, 64'd0);
    @(negedge clk);
    check64("held restart", {62'd0, busy_a, done_a}, 64'd2);
    tick = 1'b0;
    wait_done(lat);
    check64("held latency2", 64'(lat), 64'd9);
    pop_compare("held2");

    check64("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
